// File: rtl/hbfp_dot_accumulator.sv
// Accumulates signed HBFP partial sums sharing one block exponent and renormalises the total
// into an OUT_W-bit mantissa plus adjusted exponent. Define HBFP_ACC_ROUND_EN for round-half-up with clamp.
//
// state  | meaning
// S_IDLE | waiting for the first beat of a dot product
// S_ACC  | accumulating further beats
// S_NORM | one cycle: pick shift, register mantissa/exponent/error
// S_OUT  | result presented, waiting for consumer handshake
module hbfp_dot_accumulator #(
  parameter int SUM_W     = 13,
  parameter int EXP_W     = 8,
  parameter int OUT_W     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_in_valid,
  output logic               io_in_ready,
  input  logic [SUM_W-1:0]   io_in_sum,
  input  logic [EXP_W-1:0]   io_in_exp,
  input  logic               io_in_last,
  output logic               io_out_valid,
  input  logic               io_out_ready,
  output logic [OUT_W-1:0]   io_out_man,
  output logic [EXP_W:0]     io_out_exp,
  output logic               io_out_err
);

  localparam int ACC_W = SUM_W + $clog2(MAX_BEATS);
  localparam int SHMAX = ACC_W - OUT_W;
  localparam int CNT_W = $clog2(MAX_BEATS) + 1;
  localparam int SH_W  = (SHMAX > 0) ? $clog2(SHMAX + 1) : 1;

  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(MAX_BEATS - 1);
  localparam logic signed [ACC_W-1:0] FIT_MAX  = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] FIT_MIN  = ACC_W'(-(2 ** (OUT_W - 1)));

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_NORM, S_OUT} state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [EXP_W-1:0]         exp_q, exp_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     err_q, err_d;
  logic                     out_valid_q, out_valid_d;
  logic [OUT_W-1:0]         out_man_q, out_man_d;
  logic [EXP_W:0]           out_exp_q, out_exp_d;
  logic                     out_err_q, out_err_d;

  logic                     in_fire;
  logic signed [ACC_W-1:0]  sum_ext;
  logic [SH_W-1:0]          shift;
  logic [OUT_W-1:0]         norm_man;

  // Smallest shift whose arithmetic-shifted value still fits the signed output mantissa.
  function automatic logic [SH_W-1:0] find_shift(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] t;
    logic [SH_W-1:0]         s;
    s = SH_W'(SHMAX);
    for (int i = SHMAX; i >= 0; i--) begin
      t = a >>> i;
      if ((t >= FIT_MIN) && (t <= FIT_MAX)) s = SH_W'(i);
    end
    return s;
  endfunction

`ifdef HBFP_ACC_ROUND_EN
  localparam logic signed [ACC_W:0] RND_MAX = (ACC_W + 1)'((2 ** (OUT_W - 1)) - 1);
  logic signed [ACC_W:0] half;
  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] rnd_sh;
`endif

  assign io_in_ready = (state_q == S_IDLE) || (state_q == S_ACC);
  assign in_fire     = io_in_valid && io_in_ready;
  assign sum_ext     = {{(ACC_W - SUM_W){io_in_sum[SUM_W-1]}}, io_in_sum};

  always_comb begin
    shift = find_shift(acc_q);
`ifdef HBFP_ACC_ROUND_EN
    half     = (shift != '0) ? ((ACC_W + 1)'(1) << (shift - SH_W'(1))) : '0;
    rnd      = {acc_q[ACC_W-1], acc_q} + half;
    rnd_sh   = rnd >>> shift;
    norm_man = (rnd_sh > RND_MAX) ? OUT_W'(RND_MAX) : OUT_W'(rnd_sh);
`else
    norm_man = OUT_W'(acc_q >>> shift);
`endif
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    exp_d       = exp_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_man_d   = out_man_q;
    out_exp_d   = out_exp_q;
    out_err_d   = out_err_q;
    case (state_q)
      S_IDLE: begin
        if (in_fire) begin
          acc_d   = sum_ext;
          exp_d   = io_in_exp;
          cnt_d   = CNT_W'(1);
          err_d   = 1'b0;
          state_d = io_in_last ? S_NORM : S_ACC;
        end
      end
      S_ACC: begin
        if (in_fire) begin
          acc_d = acc_q + sum_ext;
          cnt_d = cnt_q + CNT_W'(1);
          err_d = err_q | (io_in_exp != exp_q);
          if (io_in_last || (cnt_q == CNT_LAST)) state_d = S_NORM;
        end
      end
      S_NORM: begin
        out_man_d   = norm_man;
        out_exp_d   = {1'b0, exp_q} + (EXP_W + 1)'(shift);
        out_err_d   = err_q;
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (io_out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      exp_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_man_q   <= '0;
      out_exp_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      exp_q       <= exp_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_man_q   <= out_man_d;
      out_exp_q   <= out_exp_d;
      out_err_q   <= out_err_d;
    end
  end

  assign io_out_valid = out_valid_q;
  assign io_out_man   = out_man_q;
  assign io_out_exp   = out_exp_q;
  assign io_out_err   = out_err_q;

endmodule

// File: tb/tb_hbfp_dot_accumulator.sv
// Directed bench for hbfp_dot_accumulator: a value-level model predicts each result from the
// accepted beats, a compare process checks outputs every cycle, and literal vectors pin the model.
module tb_hbfp_dot_accumulator;
  localparam int SUM_W = 13, EXP_W = 8, OUT_W = 8, MAX_BEATS = 16;

  logic               clock, reset;
  logic               io_in_valid, io_in_ready, io_in_last;
  logic [SUM_W-1:0]   io_in_sum;
  logic [EXP_W-1:0]   io_in_exp;
  logic               io_out_valid, io_out_ready, io_out_err;
  logic [OUT_W-1:0]   io_out_man;
  logic [EXP_W:0]     io_out_exp;

  int n_vec = 0;
  int n_err = 0;

  hbfp_dot_accumulator #(.SUM_W(SUM_W), .EXP_W(EXP_W), .OUT_W(OUT_W), .MAX_BEATS(MAX_BEATS)) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready), .io_in_sum(io_in_sum),
    .io_in_exp(io_in_exp), .io_in_last(io_in_last),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready), .io_out_man(io_out_man),
    .io_out_exp(io_out_exp), .io_out_err(io_out_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Value-level model: a dot product is the plain integer sum of its beats.
  int q_man[$];
  int q_exp[$];
  int q_err[$];
  bit busy = 1'b0;

  function automatic void predict(input int acc, input int e, input bit err);
    int s, v, m;
    s = 9;
    for (int k = 9; k >= 0; k--) begin
      v = acc >>> k;
      if (v >= -128 && v <= 127) s = k;
    end
`ifdef HBFP_ACC_ROUND_EN
    m = (acc + ((s > 0) ? (1 << (s - 1)) : 0)) >>> s;
    if (m > 127) m = 127;
`else
    m = acc >>> s;
`endif
    q_man.push_back(m);
    q_exp.push_back(e + s);
    q_err.push_back(int'(err));
  endfunction

  initial begin : model_monitor
    int m_acc, m_cnt, m_exp;
    bit m_err;
    m_acc = 0; m_cnt = 0; m_exp = 0; m_err = 1'b0;
    forever begin
      @(posedge clock);
      if (reset) begin
        m_cnt = 0;
        busy  = 1'b0;
        q_man.delete(); q_exp.delete(); q_err.delete();
      end else begin
        if (io_out_valid && io_out_ready) busy = 1'b0;
        if (io_in_valid && io_in_ready) begin
          if (m_cnt == 0) begin
            m_acc = int'($signed(io_in_sum));
            m_exp = int'(io_in_exp);
            m_err = 1'b0;
          end else begin
            m_acc = m_acc + int'($signed(io_in_sum));
            if (int'(io_in_exp) != m_exp) m_err = 1'b1;
          end
          m_cnt++;
          if (io_in_last || m_cnt == MAX_BEATS) begin
            predict(m_acc, m_exp, m_err);
            m_cnt = 0;
            busy  = 1'b1;
          end
        end
      end
    end
  end

  initial begin : compare
    bit hold;
    longint h_man, h_exp, h_err;
    hold = 1'b0; h_man = 0; h_exp = 0; h_err = 0;
    forever begin
      @(negedge clock);
      #1;
      if (reset) begin
        hold = 1'b0;
      end else begin
        chk("in_ready", longint'(io_in_ready), longint'(!busy));
        if (hold) begin
          chk("hold_valid", longint'(io_out_valid), 1);
          chk("hold_man", longint'($signed(io_out_man)), h_man);
          chk("hold_exp", longint'(io_out_exp), h_exp);
          chk("hold_err", longint'(io_out_err), h_err);
        end
        if (io_out_valid) begin
          if (io_out_ready) begin
            if (q_man.size() == 0) begin
              chk("result_expected", 0, 1);
            end else begin
              chk("model_man", longint'($signed(io_out_man)), longint'(q_man.pop_front()));
              chk("model_exp", longint'(io_out_exp), longint'(q_exp.pop_front()));
              chk("model_err", longint'(io_out_err), longint'(q_err.pop_front()));
            end
          end
          hold  = !io_out_ready;
          h_man = longint'($signed(io_out_man));
          h_exp = longint'(io_out_exp);
          h_err = longint'(io_out_err);
        end else begin
          hold = 1'b0;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the accepting posedge.
  task automatic beat(input int sum, input int e, input bit last);
    int budget;
    io_in_valid = 1'b1;
    io_in_sum   = SUM_W'(sum);
    io_in_exp   = EXP_W'(e);
    io_in_last  = last;
    budget = 0;
    while (!io_in_ready && budget < 100) begin
      @(negedge clock);
      budget++;
    end
    if (!io_in_ready) chk("beat_accept_timeout", 0, 1);
    @(posedge clock);
    @(negedge clock);
    io_in_valid = 1'b0;
    io_in_last  = 1'b0;
  endtask

  // Called at the negedge after the final beat's accept edge.
  task automatic expect_result(input string name, input int man, input int e, input bit err);
    int waited;
    chk({name, "_valid_in_norm"}, longint'(io_out_valid), 0);
    waited = 0;
    while (!io_out_valid && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    chk({name, "_latency"}, waited, 1);
    chk({name, "_man"}, longint'($signed(io_out_man)), man);
    chk({name, "_exp"}, longint'(io_out_exp), e);
    chk({name, "_err"}, longint'(io_out_err), longint'(err));
    if (io_out_ready) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; io_in_valid = 1'b0; io_in_last = 1'b0;
    io_in_sum = '0; io_in_exp = '0; io_out_ready = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_out_valid", longint'(io_out_valid), 0);
    chk("rst_out_man", longint'(io_out_man), 0);
    chk("rst_out_exp", longint'(io_out_exp), 0);
    chk("rst_out_err", longint'(io_out_err), 0);
    chk("rst_in_ready", longint'(io_in_ready), 1);
    reset = 1'b0;
    @(negedge clock);

    beat(5, 10, 1);
    expect_result("single", 5, 10, 0);

    for (int i = 0; i < 3; i++) beat(100, 10, 0);
    beat(100, 10, 1);
    expect_result("four100", 100, 12, 0);

    beat(-300, 20, 0);
    beat(-300, 20, 1);
    expect_result("neg600", -75, 23, 0);

    for (int i = 0; i < 16; i++) beat(4095, 5, 0);
    chk("forced_in_ready", longint'(io_in_ready), 0);
    expect_result("forced16", 127, 14, 0);

    beat(1, 10, 0);
    beat(2, 11, 1);
    expect_result("mismatch", 3, 10, 1);
    beat(3, 10, 1);
    expect_result("err_cleared", 3, 10, 0);

    beat(0, 33, 0);
    beat(0, 33, 1);
    expect_result("zero", 0, 33, 0);
    beat(-128, 3, 1);
    expect_result("min_fit", -128, 3, 0);
    beat(128, 3, 1);
    expect_result("just_over", 64, 4, 0);
`ifdef HBFP_ACC_ROUND_EN
    beat(129, 1, 1);
    expect_result("pos_half", 65, 2, 0);
    beat(-129, 1, 1);
    expect_result("neg_half", -64, 2, 0);
`else
    beat(129, 1, 1);
    expect_result("pos_half", 64, 2, 0);
    beat(-129, 1, 1);
    expect_result("neg_half", -65, 2, 0);
`endif

    io_out_ready = 1'b0;
    beat(-1, 7, 1);
    expect_result("hold", -1, 7, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("hold_in_ready", longint'(io_in_ready), 0);
    end
    io_out_ready = 1'b1;
    @(negedge clock);
    chk("hold_released_valid", longint'(io_out_valid), 0);

    beat(50, 9, 0);
    beat(50, 9, 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_valid", longint'(io_out_valid), 0);
    chk("midrst_in_ready", longint'(io_in_ready), 1);
    beat(7, 9, 1);
    expect_result("after_rst", 7, 9, 0);

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
